// File: rtl/fifo_burst_reader_if.sv
// FIFO read-port and downstream valid/ready stream bundle for fifo_burst_reader.
// master = the burst reader, slave = the FIFO plus downstream consumer side.
interface fifo_burst_reader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] i_fifo_dout;
  logic              i_fifo_empty;
  logic              o_fifo_rd_en;
  logic [DATA_W-1:0] o_m_data;
  logic              o_m_valid;
  logic              i_m_ready;

  modport master (
    input  i_fifo_dout, i_fifo_empty, i_m_ready,
    output o_fifo_rd_en, o_m_data, o_m_valid
  );

  modport slave (
    output i_fifo_dout, i_fifo_empty, i_m_ready,
    input  o_fifo_rd_en, o_m_data, o_m_valid
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a synchronous FIFO through a 2-entry skid buffer,
// counting and checksumming the words. Define FIFO_RD_FWFT_EN for a first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | issuing FIFO reads and handing words downstream
// DONE  | one-cycle end-of-burst pulse
module fifo_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 9
) (
  input  logic               i_sys_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  fifo_burst_reader_if.master bus,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_word_cnt,
  output logic [15:0]        o_checksum
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_cnt_q;
  logic [1:0]        occ_q;
  logic [1:0]        push_idx;
  logic [DATA_W-1:0] skid_q [2];
  logic              pop, push, inflight, rd_en;

  assign bus.o_m_valid = (occ_q != 2'd0);
  assign bus.o_m_data  = skid_q[0];
  assign pop           = bus.o_m_valid & bus.i_m_ready;

`ifdef FIFO_RD_FWFT_EN
  // Word is already on i_fifo_dout; rd_en only acknowledges it.
  assign inflight = 1'b0;
  assign push     = rd_en;
`else
  logic inflight_q;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) inflight_q <= 1'b0;
    else          inflight_q <= rd_en;
  end

  assign inflight = inflight_q;
  assign push     = inflight_q;
`endif

  // Reads are throttled so skid entries plus in-flight words never exceed two.
  assign rd_en = (state_q == READ) & ~bus.i_fifo_empty & (rem_cnt_q != '0) &
                 (({1'b0, occ_q} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign bus.o_fifo_rd_en = rd_en;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE: if (i_start) state_d = READ;
      READ: begin
        o_busy = 1'b1;
        if (pop && (o_word_cnt == LAST)) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_cnt_q  <= '0;
      o_word_cnt <= '0;
      o_checksum <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      rem_cnt_q  <= LEN;
      o_word_cnt <= '0;
      o_checksum <= '0;
    end else begin
      if (rd_en) rem_cnt_q <= rem_cnt_q - 1'b1;
      if (pop) begin
        o_word_cnt <= o_word_cnt + 1'b1;
        o_checksum <= o_checksum + skid_q[0][15:0];
      end
    end
  end

  // The incoming word lands behind whatever remains after this cycle's pop.
  assign push_idx = occ_q - {1'b0, pop};

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      occ_q     <= 2'd0;
    end else begin
      if (pop) skid_q[0] <= skid_q[1];
      if (push) begin
        if (push_idx == 2'd0) skid_q[0] <= bus.i_fifo_dout;
        else                  skid_q[1] <= bus.i_fifo_dout;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
